// File: rtl/i2c_target_responder_if.sv
// I2C pin bundle between a controller and the target responder.
// The controller drives the open-drain enables; the target returns the
// resolved wired-AND line levels.
interface i2c_target_responder_if;
    logic SCL_drive;
    logic SDA_drive;
    logic SCL_result;
    logic SDA_result;

    modport master (
        output SCL_drive,
        output SDA_drive,
        input  SCL_result,
        input  SDA_result
    );

    modport slave (
        input  SCL_drive,
        input  SDA_drive,
        output SCL_result,
        output SDA_result
    );
endinterface

// File: rtl/i2c_target_responder.sv
// I2C target responder: resolves the wired-AND bus, decodes START/STOP,
// matches a 7-bit address, and serves writes/reads against a small
// register file with an auto-incrementing pointer.
// Optional feature: define I2C_TGT_STRETCH_EN to hold SCL low for
// STRETCH_CYCLES PCLK at each ACK phase.
module i2c_target_responder #(
    parameter logic [6:0] TARGET_ADDR    = 7'h50,
    parameter int         DEPTH          = 16,
    parameter int         STRETCH_CYCLES = 8
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    i2c_target_responder_if.slave   bus,
    output logic                    bus_busy,
    output logic                    addr_match,
    output logic                    rx_valid,
    output logic [7:0]              rx_data,
    output logic                    stop_det
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ADDR     = 3'd1;
    localparam logic [2:0] ST_ADDR_ACK = 3'd2;
    localparam logic [2:0] ST_WR_BYTE  = 3'd3;
    localparam logic [2:0] ST_WR_ACK   = 3'd4;
    localparam logic [2:0] ST_RD_BYTE  = 3'd5;
    localparam logic [2:0] ST_RD_ACK   = 3'd6;
    localparam logic [2:0] ST_IGNORE   = 3'd7;

    logic [2:0]    state;
    logic          tgt_scl_low;
    logic          tgt_sda_low;
    logic          s_scl, s_sda, p_scl, p_sda;
    logic [3:0]    bit_cnt;
    logic [7:0]    shift_reg;
    logic [7:0]    tx_reg;
    logic          rw_bit;
    logic          first_byte;
    logic [AW-1:0] ptr;
    logic [7:0]    mem [DEPTH];

    logic scl_rise, scl_fall, start_cond, stop_cond, byte_done, addr_hit;

    assign bus.SCL_result = bus.SCL_drive & ~tgt_scl_low;
    assign bus.SDA_result = bus.SDA_drive & ~tgt_sda_low;

    // Bit sampling is suppressed while the target itself holds SCL low.
    assign scl_rise   = ~p_scl & s_scl & ~tgt_scl_low;
    assign scl_fall   = p_scl & ~s_scl;
    assign start_cond = p_scl & s_scl & p_sda & ~s_sda;
    assign stop_cond  = p_scl & s_scl & ~p_sda & s_sda;
    assign byte_done  = (bit_cnt == 4'd8);
    assign addr_hit   = (shift_reg[7:1] == TARGET_ADDR);

    // Two-stage sampling of the resolved lines; idle bus level is high.
    always_ff @(posedge PCLK) begin
        if (!PRESET) begin
            s_scl <= 1'b1;
            s_sda <= 1'b1;
            p_scl <= 1'b1;
            p_sda <= 1'b1;
        end else begin
            s_scl <= bus.SCL_result;
            s_sda <= bus.SDA_result;
            p_scl <= s_scl;
            p_sda <= s_sda;
        end
    end

    // Protocol FSM, register file and status pulses.
    always_ff @(posedge PCLK) begin
        if (!PRESET) begin
            state       <= ST_IDLE;
            tgt_sda_low <= 1'b0;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            tx_reg      <= '0;
            rw_bit      <= 1'b0;
            first_byte  <= 1'b0;
            ptr         <= '0;
            bus_busy    <= 1'b0;
            addr_match  <= 1'b0;
            rx_valid    <= 1'b0;
            rx_data     <= '0;
            stop_det    <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            addr_match <= 1'b0;
            rx_valid   <= 1'b0;
            stop_det   <= 1'b0;
            if (start_cond) begin
                state       <= ST_ADDR;
                bit_cnt     <= '0;
                bus_busy    <= 1'b1;
                tgt_sda_low <= 1'b0;
            end else if (stop_cond) begin
                state       <= ST_IDLE;
                bus_busy    <= 1'b0;
                stop_det    <= 1'b1;
                tgt_sda_low <= 1'b0;
            end else begin
                case (state)
                    ST_ADDR: begin
                        if (scl_rise) begin
                            shift_reg <= {shift_reg[6:0], s_sda};
                            bit_cnt   <= bit_cnt + 4'd1;
                        end else if (scl_fall && byte_done) begin
                            if (addr_hit) begin
                                addr_match  <= 1'b1;
                                tgt_sda_low <= 1'b1;
                                rw_bit      <= shift_reg[0];
                                state       <= ST_ADDR_ACK;
                            end else begin
                                state <= ST_IGNORE;
                            end
                        end
                    end
                    ST_ADDR_ACK: begin
                        if (scl_fall) begin
                            if (rw_bit) begin
                                // First read bit goes out on the same fall that ends the ACK.
                                tgt_sda_low <= ~mem[ptr][7];
                                tx_reg      <= {mem[ptr][6:0], 1'b0};
                                bit_cnt     <= 4'd1;
                                state       <= ST_RD_BYTE;
                            end else begin
                                tgt_sda_low <= 1'b0;
                                bit_cnt     <= '0;
                                first_byte  <= 1'b1;
                                state       <= ST_WR_BYTE;
                            end
                        end
                    end
                    ST_WR_BYTE: begin
                        if (scl_rise) begin
                            shift_reg <= {shift_reg[6:0], s_sda};
                            bit_cnt   <= bit_cnt + 4'd1;
                        end else if (scl_fall && byte_done) begin
                            tgt_sda_low <= 1'b1;
                            state       <= ST_WR_ACK;
                            if (first_byte) begin
                                ptr        <= shift_reg[AW-1:0];
                                first_byte <= 1'b0;
                            end else begin
                                mem[ptr] <= shift_reg;
                                rx_data  <= shift_reg;
                                rx_valid <= 1'b1;
                                ptr      <= ptr + 1'b1;
                            end
                        end
                    end
                    ST_WR_ACK: begin
                        if (scl_fall) begin
                            tgt_sda_low <= 1'b0;
                            bit_cnt     <= '0;
                            state       <= ST_WR_BYTE;
                        end
                    end
                    ST_RD_BYTE: begin
                        if (scl_fall) begin
                            if (bit_cnt == 4'd0) begin
                                // Byte after a controller ACK: load from the advanced pointer.
                                tgt_sda_low <= ~mem[ptr][7];
                                tx_reg      <= {mem[ptr][6:0], 1'b0};
                                bit_cnt     <= 4'd1;
                            end else if (byte_done) begin
                                tgt_sda_low <= 1'b0;
                                ptr         <= ptr + 1'b1;
                                state       <= ST_RD_ACK;
                            end else begin
                                tgt_sda_low <= ~tx_reg[7];
                                tx_reg      <= {tx_reg[6:0], 1'b0};
                                bit_cnt     <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    ST_RD_ACK: begin
                        if (scl_rise) begin
                            if (!s_sda) begin
                                bit_cnt <= '0;
                                state   <= ST_RD_BYTE;
                            end else begin
                                state <= ST_IGNORE;
                            end
                        end
                    end
                    ST_IDLE, ST_IGNORE: begin
                        tgt_sda_low <= 1'b0;
                    end
                    default: begin
                        state       <= ST_IDLE;
                        tgt_sda_low <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef I2C_TGT_STRETCH_EN
    logic        ack_enter;
    logic [15:0] stretch_cnt;

    assign ack_enter = scl_fall & byte_done & ~start_cond & ~stop_cond &
                       (((state == ST_ADDR) & addr_hit) | (state == ST_WR_BYTE));

    // Hold SCL low at each ACK phase; the count runs only once the
    // controller has released SCL, so the extension is exact.
    always_ff @(posedge PCLK) begin
        if (!PRESET) begin
            tgt_scl_low <= 1'b0;
            stretch_cnt <= '0;
        end else if (ack_enter) begin
            tgt_scl_low <= 1'b1;
            stretch_cnt <= 16'(STRETCH_CYCLES - 1);
        end else if (tgt_scl_low && bus.SCL_drive) begin
            if (stretch_cnt == '0) begin
                tgt_scl_low <= 1'b0;
            end else begin
                stretch_cnt <= stretch_cnt - 16'd1;
            end
        end
    end
`else
    assign tgt_scl_low = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_target_responder.sv
// Scoreboard bench for i2c_target_responder: a bit-banged controller
// pushes expected pulses and checked SDA bits into queues; a monitor
// pops and compares whenever the target presents an output.
module tb_i2c_target_responder;

    localparam int HP = 8;
    localparam int EV_ADDR = 0;
    localparam int EV_RX   = 1;
    localparam int EV_STOP = 2;

    typedef struct {
        int         kind;
        logic [7:0] val;
    } ev_t;

    logic       PCLK = 1'b0;
    logic       PRESET = 1'b0;
    logic       bus_busy, addr_match, rx_valid, stop_det;
    logic [7:0] rx_data;

    ev_t  ev_q[$];
    logic sda_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    logic chk_strobe = 1'b0;
    logic mon_en = 1'b0;

    i2c_target_responder_if bus_if ();

    i2c_target_responder #(
        .TARGET_ADDR(7'h50),
        .DEPTH(16),
        .STRETCH_CYCLES(8)
    ) dut (
        .PCLK(PCLK),
        .PRESET(PRESET),
        .bus(bus_if),
        .bus_busy(bus_busy),
        .addr_match(addr_match),
        .rx_valid(rx_valid),
        .rx_data(rx_data),
        .stop_det(stop_det)
    );

    always #5 PCLK = ~PCLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    task automatic push_ev(input int kind, input logic [7:0] val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        ev_q.push_back(e);
    endtask

    task automatic pop_ev(input int kind, input logic [7:0] val, input string name);
        ev_t e;
        if (ev_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: got unexpected pulse expected none", name);
        end else begin
            e = ev_q.pop_front();
            check({name, "_kind"}, 32'(kind), 32'(e.kind));
            check({name, "_val"}, {24'd0, val}, {24'd0, e.val});
        end
    endtask

    // Monitor: compare every presented output against the scoreboard.
    always @(negedge PCLK) begin
        if (mon_en) begin
            if (addr_match) pop_ev(EV_ADDR, 8'h00, "addr_match");
            if (rx_valid)   pop_ev(EV_RX, rx_data, "rx_valid");
            if (stop_det)   pop_ev(EV_STOP, 8'h00, "stop_det");
            if (chk_strobe) begin
                if (sda_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sda_bit: got strobe expected empty queue");
                end else begin
                    check("sda_bit", 32'(bus_if.SDA_result), 32'(sda_q.pop_front()));
                end
            end
`ifndef I2C_TGT_STRETCH_EN
            check("scl_track", 32'(bus_if.SCL_result), 32'(bus_if.SCL_drive));
`endif
        end
    end

    task automatic wait_scl_high();
        int k = 0;
        while (!bus_if.SCL_result && k < 200) begin
            tick(1);
            k++;
        end
        check("scl_release", 32'(bus_if.SCL_result), 32'd1);
    endtask

    task automatic clk_bit(input logic b, input logic chk, input logic exp_b);
        bus_if.SDA_drive = b;
        tick(4);
        if (chk) sda_q.push_back(exp_b);
        bus_if.SCL_drive = 1'b1;
        wait_scl_high();
        tick(4);
        if (chk) chk_strobe = 1'b1;
        tick(1);
        chk_strobe = 1'b0;
        tick(3);
        bus_if.SCL_drive = 1'b0;
        tick(4);
    endtask

    task automatic wr_byte(input logic [7:0] b, input logic exp_ack);
        for (int i = 7; i >= 0; i--) clk_bit(b[i], 1'b0, 1'b0);
        clk_bit(1'b1, 1'b1, ~exp_ack);
    endtask

    task automatic rd_byte(input logic [7:0] exp, input logic ack);
        for (int i = 7; i >= 0; i--) clk_bit(1'b1, 1'b1, exp[i]);
        clk_bit(~ack, 1'b0, 1'b0);
    endtask

    task automatic drv_start();
        bus_if.SDA_drive = 1'b0;
        tick(HP);
        bus_if.SCL_drive = 1'b0;
        tick(HP);
    endtask

    task automatic drv_rstart();
        bus_if.SDA_drive = 1'b1;
        tick(4);
        bus_if.SCL_drive = 1'b1;
        wait_scl_high();
        tick(HP);
        bus_if.SDA_drive = 1'b0;
        tick(HP);
        bus_if.SCL_drive = 1'b0;
        tick(4);
    endtask

    task automatic drv_stop();
        bus_if.SDA_drive = 1'b0;
        tick(4);
        bus_if.SCL_drive = 1'b1;
        wait_scl_high();
        tick(HP);
        bus_if.SDA_drive = 1'b1;
        tick(HP);
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Directed stimulus.
    initial begin
        bus_if.SCL_drive = 1'b1;
        bus_if.SDA_drive = 1'b1;
        PRESET = 1'b0;
        tick(3);
        PRESET = 1'b1;
        tick(1);
        check("rst_bus_busy", 32'(bus_busy), 32'd0);
        check("rst_addr_match", 32'(addr_match), 32'd0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_stop_det", 32'(stop_det), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_sda", 32'(bus_if.SDA_result), 32'd1);
        check("rst_scl", 32'(bus_if.SCL_result), 32'd1);
        check("rst_ptr", 32'(dut.ptr), 32'd0);
        mon_en = 1'b1;
        tick(4);

        // Write 0xA5 to register 3.
        drv_start();
        check("busy_after_start", 32'(bus_busy), 32'd1);
        push_ev(EV_ADDR, 8'h00);
        wr_byte(8'hA0, 1'b1);
        wr_byte(8'h03, 1'b1);
        push_ev(EV_RX, 8'hA5);
        wr_byte(8'hA5, 1'b1);
        push_ev(EV_STOP, 8'h00);
        drv_stop();
        check("busy_after_stop", 32'(bus_busy), 32'd0);
        check("t1_mem3", 32'(dut.mem[3]), 32'hA5);
        tick(HP);

        // Set pointer, repeated START, read two bytes (ACK then NACK).
        drv_start();
        push_ev(EV_ADDR, 8'h00);
        wr_byte(8'hA0, 1'b1);
        wr_byte(8'h03, 1'b1);
        drv_rstart();
        push_ev(EV_ADDR, 8'h00);
        wr_byte(8'hA1, 1'b1);
        rd_byte(8'hA5, 1'b1);
        rd_byte(8'h00, 1'b0);
        check("t2_ptr", 32'(dut.ptr), 32'd5);
        check("t2_ignore_sda", 32'(bus_if.SDA_result), 32'd1);
        push_ev(EV_STOP, 8'h00);
        drv_stop();
        tick(HP);

        // Non-matching address is not acknowledged.
        drv_start();
        wr_byte(8'hA2, 1'b0);
        wr_byte(8'h03, 1'b0);
        push_ev(EV_STOP, 8'h00);
        drv_stop();
        check("t3_mem3", 32'(dut.mem[3]), 32'hA5);
        check("t3_ptr", 32'(dut.ptr), 32'd5);
        tick(HP);

        // Pointer wrap from 15 to 0.
        drv_start();
        push_ev(EV_ADDR, 8'h00);
        wr_byte(8'hA0, 1'b1);
        wr_byte(8'h0F, 1'b1);
        push_ev(EV_RX, 8'h11);
        wr_byte(8'h11, 1'b1);
        push_ev(EV_RX, 8'h22);
        wr_byte(8'h22, 1'b1);
        push_ev(EV_STOP, 8'h00);
        drv_stop();
        check("t4_mem15", 32'(dut.mem[15]), 32'h11);
        check("t4_mem0", 32'(dut.mem[0]), 32'h22);
        check("t4_ptr", 32'(dut.ptr), 32'd1);
        tick(HP);

        // Pointer byte >= DEPTH is taken modulo DEPTH (0x13 -> 3).
        drv_start();
        push_ev(EV_ADDR, 8'h00);
        wr_byte(8'hA0, 1'b1);
        wr_byte(8'h13, 1'b1);
        check("t5_ptr_mod", 32'(dut.ptr), 32'd3);
        push_ev(EV_STOP, 8'h00);
        drv_stop();
        tick(HP);

        // Reset while the target holds the data ACK low.
        drv_start();
        push_ev(EV_ADDR, 8'h00);
        wr_byte(8'hA0, 1'b1);
        wr_byte(8'h03, 1'b1);
        push_ev(EV_RX, 8'h5A);
        for (int i = 7; i >= 0; i--) begin
            logic [7:0] v;
            v = 8'h5A;
            clk_bit(v[i], 1'b0, 1'b0);
        end
        bus_if.SDA_drive = 1'b1;
        tick(4);
        check("t6_ack_held", 32'(bus_if.SDA_result), 32'd0);
        PRESET = 1'b0;
        tick(1);
        PRESET = 1'b1;
        check("t6_sda_release", 32'(bus_if.SDA_result), 32'd1);
        check("t6_busy", 32'(bus_busy), 32'd0);
        check("t6_mem3", 32'(dut.mem[3]), 32'h00);
        check("t6_rx_data", 32'(rx_data), 32'h00);
        check("t6_ptr", 32'(dut.ptr), 32'd0);
        tick(2);
        push_ev(EV_STOP, 8'h00);
        drv_stop();
        tick(20);

        check("ev_queue_empty", 32'(ev_q.size()), 32'd0);
        check("sda_queue_empty", 32'(sda_q.size()), 32'd0);
        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
